bp_be_rf_wport_arbiter: RTL and testbench

Shares the single write port of a back-end register file (integer or FP instance of bp_be_regfile) among several writeback producers: pipe results, long-latency divide/FPU results, and late load returns. Each producer is decoupled by a small per-requester buffer. One buffered write is granted per cycle. The block exports a per-register pending mask that the scheduler uses to hold issue of instructions whose sources are still queued for writeback.

---
 rtl/bp_be_rf_wport_arbiter_pkg.sv | 22 ++
 rtl/bp_be_rf_wport_arbiter_if.sv | 29 ++
 rtl/bp_be_rf_wport_arbiter_fifo.sv | 72 +++++++
 rtl/bp_be_rf_wport_arbiter.sv | 121 ++++++++++++
 tb/tb_bp_be_rf_wport_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/bp_be_rf_wport_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: buffer fill states and
// the width-parameterized {addr, data} entry declaration macro.
`define BP_BE_RF_WPORT_ENTRY_DECLARE(addr_w, data_w) \
    typedef struct packed { \
        logic [addr_w-1:0] addr; \
        logic [data_w-1:0] data; \
    } bp_be_rf_wport_entry_s

package bp_be_rf_wport_arbiter_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_PARTIAL,
        BUF_FULL
    } buf_state_e;

    // Index width that stays legal when only one item is being indexed.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bp_be_rf_wport_arbiter_if.sv
// Writeback request bus and register-file write port of the write-port arbiter.
// master = producers/regfile side, slave = arbiter side.
interface bp_be_rf_wport_arbiter_if #(
    parameter int num_req_p        = 3,
    parameter int data_width_p     = 64,
    parameter int reg_addr_width_p = 5
) ();
    import bp_be_rf_wport_arbiter_pkg::*;

    logic [num_req_p-1:0]                  req_v_i;
    logic [num_req_p*reg_addr_width_p-1:0] req_addr_i;
    logic [num_req_p*data_width_p-1:0]     req_data_i;
    logic [num_req_p-1:0]                  req_ready_o;
    logic                                  rd_w_v_o;
    logic [reg_addr_width_p-1:0]           rd_addr_o;
    logic [data_width_p-1:0]               rd_data_o;
    logic [num_req_p-1:0]                  grant_o;
    logic [2**reg_addr_width_p-1:0]        pending_o;

    modport master (
        output req_v_i, req_addr_i, req_data_i,
        input  req_ready_o, rd_w_v_o, rd_addr_o, rd_data_o, grant_o, pending_o
    );

    modport slave (
        input  req_v_i, req_addr_i, req_data_i,
        output req_ready_o, rd_w_v_o, rd_addr_o, rd_data_o, grant_o, pending_o
    );
endinterface

// File: rtl/bp_be_rf_wport_arbiter_fifo.sv
// Small per-requester FIFO. Exposes every slot and its validity so the parent can
// build the pending-register mask; full is derived from registered count only.
module bp_be_rf_wport_arbiter_fifo
    import bp_be_rf_wport_arbiter_pkg::*;
#(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enq_v,
    input  logic [width_p-1:0]              enq_data,
    output logic                            enq_ready,
    output logic                            deq_v,
    output logic [width_p-1:0]              deq_data,
    input  logic                            deq_yumi,
    output logic [els_p-1:0]                els_v,
    output logic [els_p-1:0][width_p-1:0]   els_data
);
    localparam int ptr_w = $clog2(els_p);

    logic [els_p-1:0][width_p-1:0] mem_r;
    logic [ptr_w-1:0]              rptr_r, wptr_r;
    logic [ptr_w:0]                count_r;
    buf_state_e                    state;
    logic                          enq, deq;

    always_comb begin
        state = BUF_PARTIAL;
        if (count_r == '0)
            state = BUF_EMPTY;
        else if (count_r == (ptr_w+1)'(els_p))
            state = BUF_FULL;
    end

    // Ready is held low while reset is asserted, then opens immediately on release.
    assign enq_ready = (state != BUF_FULL) & reset_n;
    assign deq_v     = (state != BUF_EMPTY);
    assign enq       = enq_v & enq_ready;
    assign deq       = deq_yumi & deq_v;
    assign deq_data  = mem_r[rptr_r];
    assign els_data  = mem_r;

    always_comb begin
        logic [ptr_w-1:0] offset;
        els_v  = '0;
        offset = '0;
        for (int j = 0; j < els_p; j++) begin
            offset   = ptr_w'(j) - rptr_r;
            els_v[j] = ({1'b0, offset} < count_r);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (enq)
                wptr_r <= wptr_r + 1'b1;
            if (deq)
                rptr_r <= rptr_r + 1'b1;
            count_r <= count_r + (ptr_w+1)'(enq) - (ptr_w+1)'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (enq)
            mem_r[wptr_r] <= enq_data;
    end
endmodule

// File: rtl/bp_be_rf_wport_arbiter.sv
// Shares one register-file write port among buffered writeback producers and
// exports a per-register pending mask. BP_BE_RF_WPORT_RR_EN selects round-robin.
module bp_be_rf_wport_arbiter
    import bp_be_rf_wport_arbiter_pkg::*;
#(
    parameter int num_req_p        = 3,
    parameter int data_width_p     = 64,
    parameter int reg_addr_width_p = 5,
    parameter int buf_els_p        = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    bp_be_rf_wport_arbiter_if.slave   wp
);
    `BP_BE_RF_WPORT_ENTRY_DECLARE(reg_addr_width_p, data_width_p);

    localparam int entry_w  = $bits(bp_be_rf_wport_entry_s);
    localparam int num_regs = 2**reg_addr_width_p;

    bp_be_rf_wport_entry_s [num_req_p-1:0]                enq_entry, head;
    bp_be_rf_wport_entry_s [num_req_p-1:0][buf_els_p-1:0] els_entry;
    logic [num_req_p-1:0][buf_els_p-1:0]                  els_v;
    logic [num_req_p-1:0]                                 non_empty, grant, ready;

    for (genvar i = 0; i < num_req_p; i++) begin : g_buf
        assign enq_entry[i].addr = wp.req_addr_i[i*reg_addr_width_p +: reg_addr_width_p];
        assign enq_entry[i].data = wp.req_data_i[i*data_width_p +: data_width_p];

        bp_be_rf_wport_arbiter_fifo #(
            .width_p (entry_w),
            .els_p   (buf_els_p)
        ) u_fifo (
            .clk       (clk_i),
            .reset_n   (reset_n_i),
            .enq_v     (wp.req_v_i[i]),
            .enq_data  (enq_entry[i]),
            .enq_ready (ready[i]),
            .deq_v     (non_empty[i]),
            .deq_data  (head[i]),
            .deq_yumi  (grant[i]),
            .els_v     (els_v[i]),
            .els_data  (els_entry[i])
        );
    end

`ifdef BP_BE_RF_WPORT_RR_EN
    localparam int lg_w = safe_clog2(num_req_p);

    logic [lg_w-1:0] last_grant_r, grant_idx;

    // Search indices above the last winner first, then wrap to the rest.
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            if (!found && non_empty[i] && (lg_w'(i) > last_grant_r)) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < num_req_p; i++) begin
            if (!found && non_empty[i] && (lg_w'(i) <= last_grant_r)) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < num_req_p; i++)
            if (grant[i])
                grant_idx = lg_w'(i);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            last_grant_r <= lg_w'(num_req_p-1);
        else if (|grant)
            last_grant_r <= grant_idx;
    end
`else
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            if (!found && non_empty[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        wp.rd_addr_o = '0;
        wp.rd_data_o = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (grant[i]) begin
                wp.rd_addr_o = head[i].addr;
                wp.rd_data_o = head[i].data;
            end
        end
    end

    always_comb begin
        logic [num_regs-1:0] pend;
        pend = '0;
        for (int i = 0; i < num_req_p; i++)
            for (int j = 0; j < buf_els_p; j++)
                if (els_v[i][j])
                    pend[els_entry[i][j].addr] = 1'b1;
        wp.pending_o = pend;
    end

    assign wp.req_ready_o = ready;
    assign wp.grant_o     = grant;
    assign wp.rd_w_v_o    = |grant;
endmodule

// File: tb/tb_bp_be_rf_wport_arbiter.sv
// Directed bench for bp_be_rf_wport_arbiter; expectations follow the
// BP_BE_RF_WPORT_RR_EN setting the bench is compiled with.
module tb_bp_be_rf_wport_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    bp_be_rf_wport_arbiter_if #(.num_req_p(3), .data_width_p(64), .reg_addr_width_p(5)) wp ();

    bp_be_rf_wport_arbiter #(
        .num_req_p        (3),
        .data_width_p     (64),
        .reg_addr_width_p (5),
        .buf_els_p        (2)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .wp        (wp.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [63:0] d);
        wp.req_addr_i[i*5 +: 5]   = a;
        wp.req_data_i[i*64 +: 64] = d;
    endtask

    task automatic chk_wr(input string tag, input logic [2:0] g, input logic [4:0] a, input logic [63:0] d);
        chk({tag, "_grant"}, 64'(wp.grant_o), 64'(g));
        chk({tag, "_wv"},    64'(wp.rd_w_v_o), 64'(|g));
        chk({tag, "_addr"},  64'(wp.rd_addr_o), 64'(a));
        chk({tag, "_data"},  wp.rd_data_o, d);
    endtask

    initial begin
        reset_n       = 1'b0;
        wp.req_v_i    = '0;
        wp.req_addr_i = '0;
        wp.req_data_i = '0;
        step();
        step();
        chk("rst_ready",   64'(wp.req_ready_o), 64'h0);
        chk("rst_wv",      64'(wp.rd_w_v_o), 64'h0);
        chk("rst_grant",   64'(wp.grant_o), 64'h0);
        chk("rst_pending", 64'(wp.pending_o), 64'h0);
        #2 reset_n = 1'b1;
        #1;
        chk("rel_ready", 64'(wp.req_ready_o), 64'h7);

        // single write
        step();
        wp.req_v_i = 3'b001;
        set_req(0, 5'd5, 64'hDEAD);
        chk("sw_pend_pre", 64'(wp.pending_o), 64'h0);
        step();
        wp.req_v_i = 3'b000;
        chk_wr("sw", 3'b001, 5'd5, 64'hDEAD);
        chk("sw_pend", 64'(wp.pending_o), 64'h20);
        step();
        chk("sw_idle_wv", 64'(wp.rd_w_v_o), 64'h0);
        chk("sw_pend_off", 64'(wp.pending_o), 64'h0);

        // same-address order on requester 2
        wp.req_v_i = 3'b100;
        set_req(2, 5'd7, 64'h1);
        step();
        set_req(2, 5'd7, 64'h2);
        chk_wr("sa1", 3'b100, 5'd7, 64'h1);
        chk("sa1_pend", 64'(wp.pending_o), 64'h80);
        step();
        wp.req_v_i = 3'b000;
        chk_wr("sa2", 3'b100, 5'd7, 64'h2);
        chk("sa2_pend", 64'(wp.pending_o), 64'h80);
        step();
        chk("sa_idle_wv", 64'(wp.rd_w_v_o), 64'h0);
        chk("sa_pend_off", 64'(wp.pending_o), 64'h0);

`ifdef BP_BE_RF_WPORT_RR_EN
        // round-robin contention: data = (req << 8) | cycle
        wp.req_v_i = 3'b111;
        for (int i = 0; i < 3; i++) set_req(i, 5'(i+1), 64'((i << 8) | 0));
        chk("rr0_ready", 64'(wp.req_ready_o), 64'h7);
        step();
        for (int i = 0; i < 3; i++) set_req(i, 5'(i+1), 64'((i << 8) | 1));
        chk_wr("rr1", 3'b001, 5'd1, 64'h000);
        chk("rr1_ready", 64'(wp.req_ready_o), 64'h7);
        step();
        for (int i = 0; i < 3; i++) set_req(i, 5'(i+1), 64'((i << 8) | 2));
        chk_wr("rr2", 3'b010, 5'd2, 64'h100);
        chk("rr2_ready", 64'(wp.req_ready_o), 64'h1);
        step();
        for (int i = 0; i < 3; i++) set_req(i, 5'(i+1), 64'((i << 8) | 3));
        chk_wr("rr3", 3'b100, 5'd3, 64'h200);
        chk("rr3_ready", 64'(wp.req_ready_o), 64'h2);
        step();
        for (int i = 0; i < 3; i++) set_req(i, 5'(i+1), 64'((i << 8) | 4));
        chk_wr("rr4", 3'b001, 5'd1, 64'h001);
        chk("rr4_ready", 64'(wp.req_ready_o), 64'h4);
        step();
        wp.req_v_i = 3'b000;
        chk_wr("rr5", 3'b010, 5'd2, 64'h101);
        step();
        chk_wr("rr6", 3'b100, 5'd3, 64'h201);
        step();
        chk_wr("rr7", 3'b001, 5'd1, 64'h002);
        step();
        chk_wr("rr8", 3'b010, 5'd2, 64'h103);
        step();
        chk_wr("rr9", 3'b100, 5'd3, 64'h204);
        step();
        chk("rr_idle_wv", 64'(wp.rd_w_v_o), 64'h0);
        chk("rr_idle_pend", 64'(wp.pending_o), 64'h0);
`else
        // full-buffer boundary on requester 1 behind requester 0
        wp.req_v_i = 3'b011;
        set_req(0, 5'd1, 64'hA0);
        set_req(1, 5'd2, 64'h11);
        chk("fb0_ready", 64'(wp.req_ready_o), 64'h7);
        step();
        set_req(0, 5'd1, 64'hA1);
        set_req(1, 5'd2, 64'h12);
        chk_wr("fb1", 3'b001, 5'd1, 64'hA0);
        chk("fb1_ready", 64'(wp.req_ready_o), 64'h7);
        step();
        wp.req_v_i = 3'b010;
        set_req(1, 5'd2, 64'h13);
        chk_wr("fb2", 3'b001, 5'd1, 64'hA1);
        chk("fb2_ready", 64'(wp.req_ready_o), 64'h5);
        chk("fb2_pend", 64'(wp.pending_o), 64'h6);
        step();
        chk_wr("fb3", 3'b010, 5'd2, 64'h11);
        chk("fb3_ready_refuse", 64'(wp.req_ready_o), 64'h5);
        chk("fb3_pend", 64'(wp.pending_o), 64'h4);
        step();
        chk_wr("fb4", 3'b010, 5'd2, 64'h12);
        chk("fb4_ready", 64'(wp.req_ready_o), 64'h7);
        step();
        wp.req_v_i = 3'b000;
        chk_wr("fb5", 3'b010, 5'd2, 64'h13);
        chk("fb5_pend", 64'(wp.pending_o), 64'h4);
        step();
        chk("fb_idle_wv", 64'(wp.rd_w_v_o), 64'h0);
        chk("fb_idle_pend", 64'(wp.pending_o), 64'h0);

        // fixed priority starves requester 2
        wp.req_v_i = 3'b101;
        set_req(0, 5'd1, 64'hB0);
        set_req(2, 5'd3, 64'hD0);
        step();
        set_req(0, 5'd1, 64'hB1);
        set_req(2, 5'd3, 64'hD1);
        chk_wr("fp1", 3'b001, 5'd1, 64'hB0);
        chk("fp1_ready", 64'(wp.req_ready_o), 64'h7);
        step();
        set_req(0, 5'd1, 64'hB2);
        set_req(2, 5'd3, 64'hD2);
        chk_wr("fp2", 3'b001, 5'd1, 64'hB1);
        chk("fp2_ready", 64'(wp.req_ready_o), 64'h3);
        step();
        wp.req_v_i = 3'b000;
        chk_wr("fp3", 3'b001, 5'd1, 64'hB2);
        chk("fp3_ready", 64'(wp.req_ready_o), 64'h3);
        chk("fp3_pend", 64'(wp.pending_o), 64'hA);
        step();
        chk_wr("fp4", 3'b100, 5'd3, 64'hD0);
        step();
        chk_wr("fp5", 3'b100, 5'd3, 64'hD1);
        step();
        chk("fp_idle_wv", 64'(wp.rd_w_v_o), 64'h0);
`endif

        // reset in the middle of a drain with four entries buffered
        wp.req_v_i = 3'b111;
        set_req(0, 5'd1, 64'h50);
        set_req(1, 5'd2, 64'h51);
        set_req(2, 5'd3, 64'h52);
        step();
        wp.req_v_i = 3'b110;
        set_req(1, 5'd2, 64'h61);
        set_req(2, 5'd3, 64'h62);
        chk_wr("rm0", 3'b001, 5'd1, 64'h50);
        step();
        wp.req_v_i = 3'b000;
        chk("rm1_pend", 64'(wp.pending_o), 64'hC);
        chk_wr("rm1", 3'b010, 5'd2, 64'h51);
        #2 reset_n = 1'b0;
        #1;
        chk("rm_async_wv", 64'(wp.rd_w_v_o), 64'h0);
        chk("rm_async_grant", 64'(wp.grant_o), 64'h0);
        chk("rm_async_pend", 64'(wp.pending_o), 64'h0);
        chk("rm_async_ready", 64'(wp.req_ready_o), 64'h0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        chk("rm_rel_ready", 64'(wp.req_ready_o), 64'h7);
        chk("rm_rel_wv", 64'(wp.rd_w_v_o), 64'h0);
        chk("rm_rel_pend", 64'(wp.pending_o), 64'h0);
        step();
        chk("rm_post_wv", 64'(wp.rd_w_v_o), 64'h0);
        chk("rm_post_grant", 64'(wp.grant_o), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
